// File: rtl/tv80_alu_mc.sv
// Multi-cycle TV80-style ALU coprocessor: single-cycle Z80 add/sub/logic with
// registered results, plus iterative unsigned multiply and restoring divide.
module tv80_alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [7:0]       f_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic [7:0]       f_out,
    output logic             dz
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2, OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4, OP_XOR = 4'd5, OP_OR = 4'd6, OP_CP = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8, OP_DIV = 4'd9;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t               state_reg, state_next;
    logic [CW-1:0]        cnt_reg;
    logic                 div_reg;
    logic [WIDTH-1:0]     opnd_reg;
    logic [2*WIDTH-1:0]   acc_reg, acc_next;
    logic                 done_reg, dz_reg;
    logic [WIDTH-1:0]     q_reg, r_reg;
    logic [7:0]           f_reg;

    logic accept, multi_cycle, last_step;

    // Single-cycle datapath
    logic                 is_sub, cin, ci, ovf;
    logic [WIDTH-1:0]     bb;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     sc_q, sc_r;
    logic [7:0]           sc_f;
    logic                 sc_dz;
    logic                 fs, fz, fy, fh, fx, fp, fn, fc;

    // Iterative datapath
    logic [WIDTH:0]       mul_sum, trial;
    logic [WIDTH-1:0]     fin_q, fin_r;
    logic [7:0]           fin_f;

    always_ff @(posedge clk) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept && multi_cycle) state_next = RUN;
            RUN:  if (cnt_reg == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_reg == RUN);
        accept      = start && (state_reg == IDLE);
        last_step   = (state_reg == RUN) && (cnt_reg == '0);
        multi_cycle = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
    end

    always_comb begin
        is_sub = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
        cin    = ((op == OP_ADC) || (op == OP_SBC)) ? f_in[0] : 1'b0;
        bb     = is_sub ? ~b : b;
        ci     = is_sub ? ~cin : cin;
        sum    = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
        ovf    = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        sc_q   = a;
        sc_r   = '0;
        sc_dz  = 1'b0;
        fc = 1'b0; fn = 1'b0; fh = 1'b0; fp = 1'b0;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP: begin
                // Subtraction runs as an add of ~B, so carry outs invert into borrows.
                sc_q = sum[WIDTH-1:0];
                fc   = sum[WIDTH] ^ is_sub;
                fh   = a[4] ^ bb[4] ^ sum[4] ^ is_sub;
                fp   = ovf;
                fn   = is_sub;
            end
            OP_AND: begin sc_q = a & b; fh = 1'b1; end
            OP_XOR: sc_q = a ^ b;
            OP_OR:  sc_q = a | b;
            OP_DIV: begin
                sc_q  = '1;
                sc_r  = a;
                sc_dz = 1'b1;
                fc    = 1'b1;
            end
            default: ;
        endcase
        if ((op == OP_AND) || (op == OP_XOR) || (op == OP_OR) || (op == OP_DIV))
            fp = ~^sc_q;
        fs = sc_q[WIDTH-1];
        fz = (sc_q == '0);
        fx = (op == OP_CP) ? b[3] : sc_q[3];
        fy = (op == OP_CP) ? b[5] : sc_q[5];
        sc_f = {fs, fz, fy, fh, fx, fp, fn, fc};
        if (op > OP_DIV) sc_f = f_in;
    end

    always_comb begin
        mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
        // Upper half is the partial remainder, lower half shifts dividend out and quotient in.
        trial   = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]} - {1'b0, opnd_reg};
        if (div_reg)
            acc_next = trial[WIDTH] ? {acc_reg[2*WIDTH-2:0], 1'b0}
                                    : {trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        else
            acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
        fin_q = acc_next[WIDTH-1:0];
        fin_r = acc_next[2*WIDTH-1:WIDTH];
        if (div_reg)
            fin_f = {fin_q[WIDTH-1], fin_q == '0, fin_q[5], 1'b0, fin_q[3], ~^fin_q, 2'b00};
        else
            fin_f = {fin_r[WIDTH-1], acc_next == '0, fin_q[5], 1'b0, fin_q[3],
                     fin_r != '0, 1'b0, fin_r != '0};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_reg  <= '0;
            div_reg  <= 1'b0;
            opnd_reg <= '0;
            acc_reg  <= '0;
            done_reg <= 1'b0;
            q_reg    <= '0;
            r_reg    <= '0;
            f_reg    <= '0;
            dz_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                if (multi_cycle) begin
                    cnt_reg  <= CW'(WIDTH - 1);
                    div_reg  <= (op == OP_DIV);
                    opnd_reg <= (op == OP_DIV) ? b : a;
                    acc_reg  <= {{WIDTH{1'b0}}, (op == OP_DIV) ? a : b};
                end else begin
                    q_reg    <= sc_q;
                    r_reg    <= sc_r;
                    f_reg    <= sc_f;
                    dz_reg   <= sc_dz;
                    done_reg <= 1'b1;
                end
            end else if (state_reg == RUN) begin
                acc_reg <= acc_next;
                if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
                if (last_step) begin
                    q_reg    <= fin_q;
                    r_reg    <= fin_r;
                    f_reg    <= fin_f;
                    dz_reg   <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done  = done_reg;
    assign q     = q_reg;
    assign r     = r_reg;
    assign f_out = f_reg;
    assign dz    = dz_reg;
endmodule

// File: tb/tb_tv80_alu_mc.sv
// Scoreboard bench for tv80_alu_mc at WIDTH=16: directed vectors, a reference
// model for random ops, back-to-back handshake and reset abort.
module tb_tv80_alu_mc;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [15:0] a = '0, b = '0;
    logic [7:0]  f_in = '0;
    logic        busy, done, dz;
    logic [15:0] q, r;
    logic [7:0]  f_out;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] q, r;
        logic [7:0]  f, m;
        logic        dz;
        int          lat;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a, b;
        logic [7:0]  fi;
        exp_t        e;
    } vec_t;

    exp_t sb[$];

    tv80_alu_mc #(.WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .f_in(f_in), .busy(busy), .done(done), .q(q), .r(r), .f_out(f_out), .dz(dz)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] o, input logic [15:0] xa, input logic [15:0] xb,
                                   input logic [7:0] fi);
        exp_t e;
        int ai, bi, cin, res, sres, sa, sbv;
        longint prod;
        logic s, z, y, h, x, p, n, c;
        e.q = xa; e.r = '0; e.dz = 1'b0; e.m = 8'hFF; e.f = fi; e.lat = 1;
        ai = xa; bi = xb; sa = $signed(xa); sbv = $signed(xb);
        cin = (o == 1 || o == 3) ? int'(fi[0]) : 0;
        h = 0; p = 0; n = 0; c = 0; res = 0;
        if (o <= 3 || o == 7) begin
            if (o <= 1) begin
                res = ai + bi + cin; sres = sa + sbv + cin;
                c = (res > 65535); h = ((ai & 15) + (bi & 15) + cin) > 15;
            end else begin
                res = ai - bi - cin; sres = sa - sbv - cin;
                c = (res < 0); h = ((ai & 15) - (bi & 15) - cin) < 0; n = 1;
            end
            e.q = res[15:0];
            p = (sres > 32767) || (sres < -32768);
        end else if (o >= 4 && o <= 6) begin
            e.q = (o == 4) ? (xa & xb) : (o == 5) ? (xa ^ xb) : (xa | xb);
            h = (o == 4);
            p = ~^e.q;
        end
        if (o <= 7) begin
            s = e.q[15]; z = (e.q == 0);
            x = (o == 7) ? xb[3] : e.q[3];
            y = (o == 7) ? xb[5] : e.q[5];
            e.f = {s, z, y, h, x, p, n, c};
        end else if (o == 8) begin
            prod = longint'(xa) * longint'(xb);
            e.q = prod[15:0]; e.r = prod[31:16];
            e.f = {e.r[15], prod == 0, e.q[5], 1'b0, e.q[3], e.r != 0, 1'b0, e.r != 0};
            e.lat = 17;
        end else if (o == 9) begin
            if (xb == 0) begin
                e.q = 16'hFFFF; e.r = xa; e.dz = 1'b1; e.m = 8'hC1; e.f = 8'h81;
            end else begin
                e.q = xa / xb; e.r = xa % xb;
                e.f = {e.q[15], e.q == 0, e.q[5], 1'b0, e.q[3], ~^e.q, 2'b00};
                e.lat = 17;
            end
        end
        return e;
    endfunction

    function automatic vec_t mkv(input logic [3:0] o, input logic [15:0] xa, input logic [15:0] xb,
                                 input logic [7:0] fi, input logic [15:0] eq, input logic [15:0] er,
                                 input logic [7:0] ef, input logic [7:0] em, input logic edz,
                                 input int elat);
        vec_t v;
        v.op = o; v.a = xa; v.b = xb; v.fi = fi;
        v.e.q = eq; v.e.r = er; v.e.f = ef; v.e.m = em; v.e.dz = edz; v.e.lat = elat;
        return v;
    endfunction

    // Drives start for one cycle (cycle c) and returns in the done cycle or on timeout.
    task automatic run_op(input logic [3:0] o, input logic [15:0] xa, input logic [15:0] xb,
                          input logic [7:0] fi, output int lat, output int bcyc, output bit ovl);
        start = 1'b1; op = o; a = xa; b = xb; f_in = fi;
        lat = 0; bcyc = 0; ovl = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (busy) bcyc++;
            if (busy && done) ovl = 1;
        end while (!done && lat < 60);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy, done, dz} !== 3'b000) begin
            $display("FAIL reset_ctl busy/done/dz=%b required 000", {busy, done, dz});
            n_fail++;
        end
        n_checks++;
        if ({q, r, f_out} !== 40'h0) begin
            $display("FAIL reset_data q=%h r=%h f=%h required 0", q, r, f_out);
            n_fail++;
        end
        $display("reset: busy=%b done=%b q=%h r=%h f=%h dz=%b", busy, done, q, r, f_out, dz);
    endtask

    task automatic test_directed();
        vec_t v[$];
        exp_t e;
        int lat, bcyc;
        bit ovl;
        v.push_back(mkv(4'd0, 16'h7FFF, 16'h0001, 8'h00, 16'h8000, 16'h0000, 8'h94, 8'hFF, 1'b0, 1));
        v.push_back(mkv(4'd3, 16'h0000, 16'h0000, 8'h01, 16'hFFFF, 16'h0000, 8'hBB, 8'hFF, 1'b0, 1));
        v.push_back(mkv(4'd3, 16'h0000, 16'h0000, 8'h00, 16'h0000, 16'h0000, 8'h42, 8'hFF, 1'b0, 1));
        v.push_back(mkv(4'd4, 16'h0F0F, 16'h00FF, 8'h00, 16'h000F, 16'h0000, 8'h1C, 8'hFF, 1'b0, 1));
        v.push_back(mkv(4'd5, 16'hFFFF, 16'h0001, 8'h00, 16'hFFFE, 16'h0000, 8'hA8, 8'hFF, 1'b0, 1));
        v.push_back(mkv(4'd7, 16'h0038, 16'h0028, 8'h00, 16'h0010, 16'h0000, 8'h2A, 8'hFF, 1'b0, 1));
        v.push_back(mkv(4'd12, 16'h1234, 16'h5678, 8'hA5, 16'h1234, 16'h0000, 8'hA5, 8'hFF, 1'b0, 1));
        v.push_back(mkv(4'd8, 16'h1234, 16'h0100, 8'h00, 16'h3400, 16'h0012, 8'h05, 8'hFF, 1'b0, 17));
        v.push_back(mkv(4'd8, 16'hFFFF, 16'hFFFF, 8'h00, 16'h0001, 16'hFFFE, 8'h85, 8'hFF, 1'b0, 17));
        v.push_back(mkv(4'd9, 16'h03E8, 16'h0007, 8'h00, 16'h008E, 16'h0006, 8'h0C, 8'hFF, 1'b0, 17));
        v.push_back(mkv(4'd9, 16'h00AB, 16'h0000, 8'h00, 16'hFFFF, 16'h00AB, 8'h81, 8'hC1, 1'b1, 1));
        foreach (v[i]) begin
            sb.push_back(v[i].e);
            run_op(v[i].op, v[i].a, v[i].b, v[i].fi, lat, bcyc, ovl);
            e = sb.pop_front();
            $display("directed op=%0d a=%h b=%h -> q=%h r=%h f=%h dz=%b lat=%0d",
                     v[i].op, v[i].a, v[i].b, q, r, f_out, dz, lat);
            n_checks++;
            if (lat !== e.lat || bcyc !== e.lat - 1 || ovl) begin
                $display("FAIL dir_timing[%0d] lat=%0d busy_cycles=%0d overlap=%0d required lat=%0d busy_cycles=%0d",
                         i, lat, bcyc, ovl, e.lat, e.lat - 1);
                n_fail++;
            end
            n_checks++;
            if ({q, r, f_out & e.m, dz} !== {e.q, e.r, e.f & e.m, e.dz}) begin
                $display("FAIL dir_result[%0d] q=%h r=%h f=%h dz=%b required q=%h r=%h f=%h(mask %h) dz=%b",
                         i, q, r, f_out, dz, e.q, e.r, e.f, e.m, e.dz);
                n_fail++;
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [3:0] o;
        logic [15:0] xa, xb;
        logic [7:0] fi;
        int lat, bcyc;
        bit ovl;
        for (int i = 0; i < 40; i++) begin
            o  = 4'($urandom_range(0, 15));
            xa = 16'($urandom);
            xb = 16'($urandom);
            fi = 8'($urandom);
            if (o == 4'd9 && $urandom_range(0, 3) == 0) xb = '0;
            sb.push_back(model(o, xa, xb, fi));
            run_op(o, xa, xb, fi, lat, bcyc, ovl);
            e = sb.pop_front();
            $display("random op=%0d a=%h b=%h f_in=%h -> q=%h r=%h f=%h dz=%b lat=%0d",
                     o, xa, xb, fi, q, r, f_out, dz, lat);
            n_checks++;
            if (lat !== e.lat || bcyc !== e.lat - 1 || ovl) begin
                $display("FAIL rnd_timing[%0d] lat=%0d busy_cycles=%0d overlap=%0d required lat=%0d",
                         i, lat, bcyc, ovl, e.lat);
                n_fail++;
            end
            n_checks++;
            if ({q, r, f_out & e.m, dz} !== {e.q, e.r, e.f & e.m, e.dz}) begin
                $display("FAIL rnd_result[%0d] q=%h r=%h f=%h dz=%b required q=%h r=%h f=%h dz=%b",
                         i, q, r, f_out, dz, e.q, e.r, e.f, e.dz);
                n_fail++;
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int dones = 0, first = -1, second = -1;
        bit q_held = 1'b1;
        sb.push_back(model(4'd8, 16'h1234, 16'h0100, 8'h00));
        sb.push_back(model(4'd8, 16'hFFFF, 16'hFFFF, 8'h00));
        start = 1'b1; op = 4'd8; a = 16'h1234; b = 16'h0100; f_in = 8'h00;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin a = 16'hFFFF; b = 16'hFFFF; end
            if (first > 0 && cyc > first && !done && q !== 16'h3400 && second < 0) q_held = 1'b0;
            if (done) begin
                dones++;
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
                e = sb.size() > 0 ? sb.pop_front() : '{default: '0};
                $display("b2b done cycle=%0d q=%h r=%h f=%h", cyc, q, r, f_out);
                n_checks++;
                if ({q, r, f_out} !== {e.q, e.r, e.f}) begin
                    $display("FAIL b2b_result cycle=%0d q=%h r=%h f=%h required q=%h r=%h f=%h",
                             cyc, q, r, f_out, e.q, e.r, e.f);
                    n_fail++;
                end
            end
            if (first > 0 && cyc == first + 1) start = 1'b0;
        end
        start = 1'b0;
        n_checks++;
        if (first !== 17 || second !== 34 || dones !== 2) begin
            $display("FAIL b2b_timing first=%0d second=%0d dones=%0d required 17 34 2", first, second, dones);
            n_fail++;
        end
        n_checks++;
        if (!q_held) begin
            $display("FAIL b2b_hold q changed before second done, required 3400");
            n_fail++;
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int lat, bcyc, spurious = 0;
        bit ovl;
        start = 1'b1; op = 4'd8; a = 16'h1234; b = 16'h0100; f_in = 8'h00;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc == 5) reset_n = 1'b0;
            if (cyc == 6) begin
                $display("abort: busy=%b done=%b q=%h r=%h f=%h dz=%b", busy, done, q, r, f_out, dz);
                n_checks++;
                if ({busy, done, dz, q, r, f_out} !== 43'h0) begin
                    $display("FAIL abort_clear busy=%b done=%b q=%h r=%h f=%h dz=%b required all 0",
                             busy, done, q, r, f_out, dz);
                    n_fail++;
                end
                reset_n = 1'b1;
            end
            if (cyc > 6 && (done || busy)) spurious++;
        end
        n_checks++;
        if (spurious !== 0) begin
            $display("FAIL abort_quiet activity_cycles=%0d required 0", spurious);
            n_fail++;
        end
        sb.push_back(model(4'd0, 16'h0001, 16'h0001, 8'h00));
        run_op(4'd0, 16'h0001, 16'h0001, 8'h00, lat, bcyc, ovl);
        e = sb.pop_front();
        $display("post-abort ADD 1+1 -> q=%h f=%h lat=%0d", q, f_out, lat);
        n_checks++;
        if (lat !== 1 || q !== 16'h0002 || {r, f_out, dz} !== {e.r, e.f, e.dz}) begin
            $display("FAIL abort_add lat=%0d q=%h r=%h f=%h required lat=1 q=0002 r=%h f=%h",
                     lat, q, r, f_out, e.r, e.f);
            n_fail++;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tv80_alu_mc.md
Name: tv80_alu_mc

Overview:
- Parametrised, multi-cycle successor to the combinational TV80 8-bit ALU.
- Performs Z80-style add/sub/logic on WIDTH-bit operands with registered results and Z80 flag semantics.
- Adds iterative unsigned multiply and divide, behind a start/busy/done handshake.
- Sits beside the core datapath as a coprocessor for extended 16-bit and wider arithmetic instructions.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 8..32.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- op  in  4  operation: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP, 8 MUL, 9 DIV, 10-15 reserved
- a  in  WIDTH  operand A / dividend / multiplicand
- b  in  WIDTH  operand B / divisor / multiplier
- f_in  in  8  incoming flags; bit positions C0 N1 P2 X3 H4 Y5 Z6 S7
- busy  out  1  high while a MUL/DIV iteration is in progress
- done  out  1  one-cycle pulse; q, r, f_out and dz valid from this cycle
- q  out  WIDTH  result / product low half / quotient
- r  out  WIDTH  product high half / remainder; 0 for non-MUL/DIV ops
- f_out  out  8  result flags
- dz  out  1  divide-by-zero indicator for the last DIV; 0 for other ops

Behaviour:
- Reset: when reset_n=0 at a clock edge: state IDLE; busy, done, q, r, f_out, dz all 0; iteration counter 0. Reset overrides start and any in-flight op; aborted results are discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, performing MUL/DIV iterations.
  - Return to IDLE: done pulses on the edge that returns the FSM to IDLE.
- Handshake:
  - start with busy=0 latches op, a, b and f_in.
  - start with busy=1 is ignored, with no queueing.
  - start in the done cycle is accepted, so back-to-back operation is allowed.
  - done is never high together with busy.
- Single-cycle ops (0-7, 10-15, and DIV by zero): start in cycle c gives done and results in cycle c+1. FSM stays IDLE.
- MUL and DIV (b≠0): start in cycle c; busy=1 in cycles c+1..c+WIDTH; done=1, busy=0 in cycle c+WIDTH+1.
  - One shift-add (MUL) or restoring shift-subtract (DIV) step per RUN cycle.
  - The counter loads WIDTH-1 and the final step writes outputs.
- Outputs hold their last values between done pulses.
- Arithmetic (ops 0-3, 7):
  - Carry-in = f_in.C for ADC/SBC, otherwise 0.
  - Subtraction is A + ~B + ~cin; C = borrow.
  - H = carry/borrow out of bit 3.
  - P/V = signed overflow at the MSB.
  - N = 1 for SUB/SBC/CP, otherwise 0.
  - CP: q = A-B, and X/Y are taken from b[3]/b[5].
- Logic (ops 4-6): C=0, N=0; H=1 for AND, 0 for XOR/OR; P/V = even parity of all WIDTH bits of q.
- Common flags for ops 0-7: S = q[WIDTH-1]; Z = (q==0); X = q[3]; Y = q[5], except for CP.
- MUL (unsigned, {r,q} = a*b):
  - C = P/V = (r≠0).
  - Z = ({r,q}==0).
  - S = r[WIDTH-1].
  - H = N = 0; X/Y from q.
- DIV (unsigned, q = a/b, r = a%b):
  - C = 0; Z = (q==0); S = q[WIDTH-1]; H = N = 0; P/V = parity(q).
- Divide by zero (b=0): q = all ones, r = a, dz = 1, C = 1, Z = 0, S = 1. Completes in 1 cycle and never enters RUN.
- Reserved ops: q = a, r = 0, f_out = f_in, done pulses normally.
- Widths: internal sums use WIDTH+1 bits; the product accumulator uses 2*WIDTH bits; no truncation before flag extraction.

Test Plan (WIDTH=16):
- ADD a=0x7FFF, b=0x0001, start in cycle c → cycle c+1: done=1, q=0x8000, r=0, S=1, Z=0, H=1, P/V=1, N=0, C=0.
- SBC a=0x0000, b=0x0000, f_in.C=1 → q=0xFFFF, C=1, N=1, H=1, S=1, P/V=0, Z=0. Same with f_in.C=0 → q=0, Z=1, C=0.
- MUL a=0x1234, b=0x0100, start in cycle c → busy high exactly cycles c+1..c+16; done in cycle c+17; q=0x3400, r=0x0012, C=1, P/V=1. Also check a=0xFFFF, b=0xFFFF → q=0x0001, r=0xFFFE.
- DIV a=0x03E8, b=0x0007 → done in cycle c+17; q=0x008E, r=0x0006, dz=0, C=0. DIV a=0x00AB, b=0 → done in cycle c+1; q=0xFFFF, r=0x00AB, dz=1, C=1.
- Hold start high for the whole duration of a MUL → only one done pulse; the second op starts on the done cycle and its done arrives 17 cycles later. q keeps the first result until then.
- Assert reset_n=0 in cycle c+5 of a MUL → next cycle busy=0, done=0, q=r=f_out=0, dz=0. No done pulse follows; a following ADD 1+1 yields q=0x0002 in 1 cycle.
